// File: rtl/pc_sequencer_pkg.sv
// Shared core constants: switch levels, branch funct3 codes,
// control-transfer kinds and fetch sequencer state encodings.
package pc_sequencer_pkg;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam logic [1:0] CTRL_NONE   = 2'd0;
    localparam logic [1:0] CTRL_BRANCH = 2'd1;
    localparam logic [1:0] CTRL_JAL    = 2'd2;
    localparam logic [1:0] CTRL_JALR   = 2'd3;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic        taken;
        logic        misaligned;
        logic [31:0] target;
    } xfer_t;

    function automatic logic [31:0] next_seq(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// Resolves the execute-stage control transfer into a taken flag,
// a fetch target and a misalignment flag.
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic        ex_valid,
    input  logic [1:0]  ctrl_type,
    input  logic        branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output xfer_t       xfer
);

    logic [31:0] pc_rel;
    logic [31:0] reg_rel;

    always_comb begin
        pc_rel  = ex_pc + imm;
        reg_rel = (rs1 + imm) & ~32'h1;
        xfer    = '0;
        unique case (ctrl_type)
            CTRL_NONE: begin
                xfer.taken = OFF;
            end
            CTRL_BRANCH: begin
                xfer.taken  = branch;
                xfer.target = pc_rel;
            end
            CTRL_JAL: begin
                xfer.taken  = ON;
                xfer.target = pc_rel;
            end
            CTRL_JALR: begin
                xfer.taken  = ON;
                xfer.target = reg_rel;
            end
        endcase
        xfer.taken      = xfer.taken & ex_valid;
        // Bit 0 is always clear here; only bit 1 can break word alignment
        xfer.misaligned = xfer.taken & xfer.target[1];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC holder and redirect stage: sequential advance, taken
// transfers and misaligned-target traps to a fixed vector.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0040_0004
)
(
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iStall,
    input  logic        iInstrReady,
    output logic        oFetchReq,
    output logic [31:0] oPC,
    input  logic        iExValid,
    input  logic [1:0]  iCtrlType,
    input  logic        iBranch,
    input  logic [31:0] iExPC,
    input  logic [31:0] iImm,
    input  logic [31:0] iRs1,
    output logic        oRedirect,
    output logic [31:0] oLinkPC,
    output logic        oMisaligned,
    output logic [31:0] oBadAddr
);

    seq_state_t  state;
    xfer_t       xfer;
    logic [31:0] pc;
    logic [31:0] bad_addr;
    logic        fetch_req;
    logic        mis;

    pc_target_calc u_calc (
        .ex_valid  (iExValid),
        .ctrl_type (iCtrlType),
        .branch    (iBranch),
        .ex_pc     (iExPC),
        .imm       (iImm),
        .rs1       (iRs1),
        .xfer      (xfer)
    );

    // Flush also fires on the misaligned cycle so upstream is clean before the trap
    assign oRedirect   = iRST_N & (state == ST_RUN) & xfer.taken;
    assign oLinkPC     = next_seq(iExPC);
    assign oPC         = pc;
    assign oFetchReq   = fetch_req;
    assign oMisaligned = mis;
    assign oBadAddr    = bad_addr;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_BOOT;
            pc        <= RESET_VECTOR;
            bad_addr  <= '0;
            fetch_req <= OFF;
            mis       <= OFF;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    state     <= ST_RUN;
                    fetch_req <= ON;
                end
                ST_RUN: begin
                    if (xfer.misaligned) begin
                        bad_addr  <= xfer.target;
                        pc        <= TRAP_VECTOR;
                        state     <= ST_TRAP;
                        fetch_req <= OFF;
                        mis       <= ON;
                    end else if (xfer.taken) begin
                        pc <= xfer.target;
                    end else if (iInstrReady && !iStall) begin
                        pc <= next_seq(pc);
                    end
                end
                ST_TRAP: begin
                    state     <= ST_RUN;
                    fetch_req <= ON;
                    mis       <= OFF;
                end
                default: begin
                    state     <= ST_BOOT;
                    pc        <= RESET_VECTOR;
                    fetch_req <= OFF;
                    mis       <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table, reset-in-trap sequence and randomized run against
// a cycle-level behavioural model of the fetch sequencer.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] TV = 32'h0040_0004;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iStall = 1'b0;
    logic        iInstrReady = 1'b0;
    logic        oFetchReq;
    logic [31:0] oPC;
    logic        iExValid = 1'b0;
    logic [1:0]  iCtrlType = CTRL_NONE;
    logic        iBranch = 1'b0;
    logic [31:0] iExPC = '0;
    logic [31:0] iImm = '0;
    logic [31:0] iRs1 = '0;
    logic        oRedirect;
    logic [31:0] oLinkPC;
    logic        oMisaligned;
    logic [31:0] oBadAddr;

    int nvec = 0;
    int nbad = 0;

    pc_sequencer dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iStall      (iStall),
        .iInstrReady (iInstrReady),
        .oFetchReq   (oFetchReq),
        .oPC         (oPC),
        .iExValid    (iExValid),
        .iCtrlType   (iCtrlType),
        .iBranch     (iBranch),
        .iExPC       (iExPC),
        .iImm        (iImm),
        .iRs1        (iRs1),
        .oRedirect   (oRedirect),
        .oLinkPC     (oLinkPC),
        .oMisaligned (oMisaligned),
        .oBadAddr    (oBadAddr)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic        stall;
        logic        ready;
        logic        exv;
        logic [1:0]  ctl;
        logic        br;
        logic [31:0] expc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] e_pc;
        logic        e_fetch;
        logic        e_redir;
        logic        e_mis;
        logic [31:0] e_bad;
        logic [31:0] e_link;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(
        input logic st, input logic rd, input logic ev,
        input logic [1:0] ct, input logic b,
        input logic [31:0] xp, input logic [31:0] im, input logic [31:0] r1,
        input logic [31:0] pc, input logic fr, input logic rdr,
        input logic ms, input logic [31:0] bad, input logic [31:0] lk);
        vec_t v;
        v.stall = st; v.ready = rd; v.exv = ev; v.ctl = ct; v.br = b;
        v.expc = xp; v.imm = im; v.rs1 = r1;
        v.e_pc = pc; v.e_fetch = fr; v.e_redir = rdr; v.e_mis = ms;
        v.e_bad = bad; v.e_link = lk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic ev,
                         input logic [1:0] ct, input logic b,
                         input logic [31:0] xp, input logic [31:0] im,
                         input logic [31:0] r1);
        iStall = st; iInstrReady = rd; iExValid = ev; iCtrlType = ct;
        iBranch = b; iExPC = xp; iImm = im; iRs1 = r1;
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        drive(0, 1, 0, CTRL_NONE, 0, 0, 0, 0);
        repeat (2) @(posedge iCLK);
        #2 iRST_N = 1'b1;
    endtask

    // Behavioural model state
    bit          m_boot;
    bit          m_trap;
    logic [31:0] m_pc;
    logic [31:0] m_bad;

    task automatic model_check_step(input string tag);
        logic [31:0] t;
        bit tk;
        bit running;
        t = 32'h0;
        tk = 0;
        if (iCtrlType == CTRL_BRANCH || iCtrlType == CTRL_JAL)
            t = iExPC + iImm;
        else if (iCtrlType == CTRL_JALR) begin
            t = iRs1 + iImm;
            t[0] = 1'b0;
        end
        tk = iExValid && (iCtrlType == CTRL_JAL || iCtrlType == CTRL_JALR ||
                          (iCtrlType == CTRL_BRANCH && iBranch));
        running = !m_boot && !m_trap;
        chk({tag, " pc"}, oPC, m_pc);
        chk({tag, " fetch"}, 32'(oFetchReq), 32'(running));
        chk({tag, " redirect"}, 32'(oRedirect), 32'(running && tk));
        chk({tag, " mis"}, 32'(oMisaligned), 32'(m_trap));
        chk({tag, " bad"}, oBadAddr, m_bad);
        chk({tag, " link"}, oLinkPC, iExPC + 32'd4);
        if (m_boot) m_boot = 0;
        else if (m_trap) m_trap = 0;
        else if (tk && t[1]) begin
            m_bad = t; m_pc = TV; m_trap = 1;
        end else if (tk) m_pc = t;
        else if (iInstrReady && !iStall) m_pc = m_pc + 32'd4;
    endtask

    initial begin
        tbl[0]  = mk(0,1,0,CTRL_NONE,0,0,0,0, RV,0,0,0,0,4);
        tbl[1]  = mk(0,1,0,CTRL_NONE,0,0,0,0, RV,1,0,0,0,4);
        tbl[2]  = mk(0,1,0,CTRL_NONE,0,0,0,0, 32'h0040_0004,1,0,0,0,4);
        tbl[3]  = mk(0,1,0,CTRL_NONE,0,0,0,0, 32'h0040_0008,1,0,0,0,4);
        tbl[4]  = mk(0,1,0,CTRL_NONE,0,0,0,0, 32'h0040_000C,1,0,0,0,4);
        tbl[5]  = mk(1,1,0,CTRL_NONE,0,0,0,0, 32'h0040_0010,1,0,0,0,4);
        tbl[6]  = mk(1,1,0,CTRL_NONE,0,0,0,0, 32'h0040_0010,1,0,0,0,4);
        tbl[7]  = mk(1,1,0,CTRL_NONE,0,0,0,0, 32'h0040_0010,1,0,0,0,4);
        tbl[8]  = mk(0,1,0,CTRL_NONE,0,0,0,0, 32'h0040_0010,1,0,0,0,4);
        tbl[9]  = mk(0,1,1,CTRL_BRANCH,1,32'h0040_0020,32'hFFFF_FFF0,0,
                     32'h0040_0014,1,1,0,0,32'h0040_0024);
        tbl[10] = mk(0,1,1,CTRL_BRANCH,0,32'h0040_0020,32'hFFFF_FFF0,0,
                     32'h0040_0010,1,0,0,0,32'h0040_0024);
        tbl[11] = mk(0,1,1,CTRL_JALR,0,32'h0040_0030,3,32'h0040_0101,
                     32'h0040_0014,1,1,0,0,32'h0040_0034);
        tbl[12] = mk(0,1,1,CTRL_JALR,0,32'h0040_0030,0,32'h0040_0102,
                     32'h0040_0104,1,1,0,0,32'h0040_0034);
        tbl[13] = mk(0,1,1,CTRL_JAL,0,0,8,0,
                     TV,0,0,1,32'h0040_0102,4);
        tbl[14] = mk(0,1,0,CTRL_NONE,0,0,0,0,
                     TV,1,0,0,32'h0040_0102,4);
        tbl[15] = mk(1,0,1,CTRL_JAL,0,32'hFFFF_FFF0,32,0,
                     32'h0040_0008,1,1,0,32'h0040_0102,32'hFFFF_FFF4);
        tbl[16] = mk(0,0,0,CTRL_NONE,0,0,0,0,
                     32'h0000_0010,1,0,0,32'h0040_0102,4);
        tbl[17] = mk(0,1,0,CTRL_NONE,0,0,0,0,
                     32'h0000_0010,1,0,0,32'h0040_0102,4);
        tbl[18] = mk(0,1,1,CTRL_NONE,0,32'h40,8,0,
                     32'h0000_0014,1,0,0,32'h0040_0102,32'h44);
        tbl[19] = mk(0,1,0,CTRL_NONE,0,0,0,0,
                     32'h0000_0018,1,0,0,32'h0040_0102,4);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            drive(tbl[i].stall, tbl[i].ready, tbl[i].exv, tbl[i].ctl,
                  tbl[i].br, tbl[i].expc, tbl[i].imm, tbl[i].rs1);
            #1;
            chk($sformatf("tbl%0d pc", i), oPC, tbl[i].e_pc);
            chk($sformatf("tbl%0d fetch", i), 32'(oFetchReq), 32'(tbl[i].e_fetch));
            chk($sformatf("tbl%0d redirect", i), 32'(oRedirect), 32'(tbl[i].e_redir));
            chk($sformatf("tbl%0d mis", i), 32'(oMisaligned), 32'(tbl[i].e_mis));
            chk($sformatf("tbl%0d bad", i), oBadAddr, tbl[i].e_bad);
            chk($sformatf("tbl%0d link", i), oLinkPC, tbl[i].e_link);
        end

        // Reset asserted while in the trap cycle
        @(negedge iCLK);
        drive(0, 1, 1, CTRL_JAL, 0, 32'h100, 2, 0);
        #1 chk("rsttrap detect redirect", 32'(oRedirect), 1);
        @(negedge iCLK);
        #1;
        chk("rsttrap mis", 32'(oMisaligned), 1);
        chk("rsttrap pc", oPC, TV);
        chk("rsttrap bad", oBadAddr, 32'h102);
        iRST_N = 1'b0;
        #1;
        chk("rsttrap cleared mis", 32'(oMisaligned), 0);
        chk("rsttrap cleared pc", oPC, RV);
        chk("rsttrap cleared fetch", 32'(oFetchReq), 0);
        chk("rsttrap cleared redirect", 32'(oRedirect), 0);
        chk("rsttrap cleared bad", oBadAddr, 0);
        @(posedge iCLK);
        #2 iRST_N = 1'b1;
        @(negedge iCLK);
        drive(0, 1, 0, CTRL_NONE, 0, 0, 0, 0);
        #1;
        chk("reboot fetch", 32'(oFetchReq), 0);
        chk("reboot pc", oPC, RV);
        @(negedge iCLK);
        #1;
        chk("rerun fetch", 32'(oFetchReq), 1);
        chk("rerun pc", oPC, RV);

        // Randomized run against the model
        do_reset();
        m_boot = 1; m_trap = 0; m_pc = RV; m_bad = '0;
        for (int c = 0; c < 500; c++) begin
            logic [31:0] im;
            @(negedge iCLK);
            im = 32'($urandom_range(0, 63)) - 32'd32;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom() & ~32'h3, im,
                  $urandom());
            #1;
            model_check_step($sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch-redirect stage of the core, directly downstream of the branch evaluator. It holds the architectural fetch PC and drives the instruction-memory fetch handshake. Each cycle it takes the execute-stage control-transfer outcome (branch decision, JAL, JALR) and either advances sequentially or redirects fetch and flushes upstream. Misaligned targets trap to a fixed vector.

## Interface

Parameters:
- RESET_VECTOR, 32'h0040_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0040_0004, fetch address after a misaligned-target trap

Ports:
- iCLK  in  1  core clock, rising edge
- iRST_N  in  1  asynchronous, active-low reset
- iStall  in  1  hazard hold; PC must not advance sequentially
- iInstrReady  in  1  instruction memory returns data for oPC this cycle
- oFetchReq  out  1  fetch request for oPC
- oPC  out  32  current fetch address, registered
- iExValid  in  1  execute-stage instruction valid and resolved this cycle
- iCtrlType  in  2  CTRL_NONE / CTRL_BRANCH / CTRL_JAL / CTRL_JALR
- iBranch  in  1  branch-taken decision from the branch evaluator
- iExPC  in  32  PC of the execute-stage instruction
- iImm  in  32  sign-extended immediate
- iRs1  in  32  rs1 operand (JALR base)
- oRedirect  out  1  combinational flush of fetch/decode, same cycle as the transfer
- oLinkPC  out  32  iExPC + 4, combinational, for rd writeback
- oMisaligned  out  1  one-cycle trap pulse, registered
- oBadAddr  out  32  offending target of the most recent trap, registered

## Operation

- States: BOOT, RUN, TRAP.
- BOOT: entered on reset. oPC = RESET_VECTOR, oFetchReq = 0. Next cycle goes to RUN unconditionally.
- RUN: oFetchReq = 1.
- Taken = iExValid & ((iCtrlType==CTRL_BRANCH & iBranch) | iCtrlType==CTRL_JAL | iCtrlType==CTRL_JALR).
- Target: BRANCH/JAL = iExPC + iImm. JALR = (iRs1 + iImm) & ~32'h1. All arithmetic is modulo 2^32; wrap-around is silent.
- Misaligned = Taken & (Target[1] != 0). No compressed instructions.
- In RUN, priority is highest first:
  - Misaligned: oBadAddr <= Target, oPC <= TRAP_VECTOR, go to TRAP.
  - Taken: oPC <= Target; oRedirect = 1 this cycle. Redirect overrides iStall and iInstrReady.
  - iInstrReady & ~iStall: oPC <= oPC + 4.
  - Otherwise: hold.
- A not-taken branch and CTRL_NONE never redirect.
- TRAP: oMisaligned = 1, oFetchReq = 0, oRedirect = 0. iExValid is ignored. Next cycle goes to RUN.
- Changing oPC with a fetch outstanding abandons that fetch. Instruction memory is address-combinational and must tolerate this.
- oRedirect is also asserted combinationally in the misaligned cycle, so upstream is flushed before the trap.

## Timing

- Reset values: oPC = RESET_VECTOR, oFetchReq = 0, oMisaligned = 0, oBadAddr = 0, state = BOOT. oRedirect is forced to 0 while iRST_N = 0.
- First fetch request: second rising edge after reset deassert, i.e. one BOOT cycle.
- Redirect latency: oRedirect in cycle N; new oPC visible in cycle N+1.
- Sequential advance: one cycle per accepted fetch; zero-wait memory sustains one instruction per cycle.
- Trap: cycle N detects; N+1 is TRAP (oPC = TRAP_VECTOR, oMisaligned = 1); N+2 is RUN with the fetch of TRAP_VECTOR.
- Reset asserted mid-operation clears all state immediately. Pending redirects and traps are discarded.
- iExValid = 1 together with iStall = 1: the redirect is taken and the stall is ignored for PC purposes. The hazard unit must deassert iExValid while execute is itself stalled.

## Structure

- Shared config constants: CTRL_NONE = 2'd0, CTRL_BRANCH = 2'd1, CTRL_JAL = 2'd2, CTRL_JALR = 2'd3, plus state encodings for BOOT/RUN/TRAP. These live with the existing ON/OFF and FUNCT3 definitions.
- Sub-module pc_target_calc: combinational Target, Taken and Misaligned computation from iCtrlType/iBranch/iExPC/iImm/iRs1. The sequencer keeps the FSM and registers.

## Test plan

- Reset then release, iInstrReady = 1: cycle 1 oFetchReq = 0, oPC = 32'h0040_0000; then oPC = 32'h0040_0000, 32'h0040_0004, 32'h0040_0008 on consecutive cycles.
- iStall = 1 for 3 cycles at oPC = 32'h0040_0010: oPC holds 32'h0040_0010 for those 3 cycles, then resumes +4.
- BRANCH, iBranch = 1, iExPC = 32'h0040_0020, iImm = -16: oRedirect = 1 that cycle, next oPC = 32'h0040_0010, oLinkPC = 32'h0040_0024. Same with iBranch = 0: no redirect.
- JALR, iRs1 = 32'h0040_0101, iImm = 3: Target = 32'h0040_0104, redirect. iRs1 = 32'h0040_0102, iImm = 0: Target bit1 = 1, so oMisaligned pulses one cycle, oBadAddr = 32'h0040_0102, oPC = TRAP_VECTOR.
- JAL, iExPC = 32'hFFFF_FFF0, iImm = 32: oPC wraps to 32'h0000_0010. A JAL together with iStall = 1 and iInstrReady = 0 still redirects.
- Assert iRST_N low during the TRAP state: oMisaligned = 0 and oPC = RESET_VECTOR immediately. The sequence restarts from BOOT.
